// File: rtl/PKG_pwm.sv
// Shared PWM types: carrier enable, update-mode selector, update-scheduler FSM
// states, and the qualifying-event decode used by the scheduler.
package PKG_pwm;

   localparam int PWMCOUNT_WIDTH = 16;

   typedef enum logic {
      PWM_OFF = 1'b0,
      PWM_ON  = 1'b1
   } _pwm_onoff;

   typedef enum logic [1:0] {
      UPD_ZERO      = 2'd0,
      UPD_MAX       = 2'd1,
      UPD_BOTH      = 2'd2,
      UPD_IMMEDIATE = 2'd3
   } _pwm_upd_mode;

   typedef enum logic [1:0] {
      UPD_ST_IDLE  = 2'd0,
      UPD_ST_ARMED = 2'd1,
      UPD_ST_APPLY = 2'd2
   } _pwm_upd_state;

   // One qualifying event per cycle; coincident zero and max collapse into one.
   // Immediate mode never counts events, since it does not wait for the carrier.
   function automatic logic upd_event(input _pwm_upd_mode mode,
                                      input logic cnt_zero,
                                      input logic cnt_max);
      logic evt;
      case (mode)
         UPD_ZERO: evt = cnt_zero;
         UPD_MAX:  evt = cnt_max;
         UPD_BOTH: evt = cnt_zero | cnt_max;
         default:  evt = 1'b0;
      endcase
      return evt;
   endfunction

endpackage

// File: rtl/pwm_update_scheduler.sv
// PWM shadow-register update scheduler. A software commit is armed, waits for
// the (ratio+1)-th qualifying carrier event (or applies at once in immediate
// mode or when the carrier is off), then pulses mask_event for one cycle so
// every shadow register mask takes its new value together.
module pwm_update_scheduler
   import PKG_pwm::*;
#(
   parameter int RATIO_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  _pwm_onoff              pwm_onoff,
   input  logic                   cnt_zero,
   input  logic                   cnt_max,
   input  _pwm_upd_mode           upd_mode,
   input  logic [RATIO_WIDTH-1:0] upd_ratio,
   input  logic                   commit_req,
   output logic                   mask_event,
   output logic                   commit_busy,
   output logic                   commit_done,
   output logic                   commit_err
);

   _pwm_upd_state          state;
   _pwm_upd_mode           mode_q;
   logic [RATIO_WIDTH-1:0] ratio_q;
   logic [RATIO_WIDTH-1:0] ratio_cnt;

   logic evt;
   logic ratio_hit;
   logic apply_now;

   // Decode the armed commit's release condition from the latched settings only,
   // so live upd_mode/upd_ratio changes cannot disturb a pending commit.
   always_comb begin
      evt       = upd_event(mode_q, cnt_zero, cnt_max);
      ratio_hit = (ratio_cnt == ratio_q);
      apply_now = (pwm_onoff == PWM_OFF) ||
                  (mode_q == UPD_IMMEDIATE) ||
                  (evt && ratio_hit);
   end

   // Scheduler FSM; outputs are registered from the next state so mask_event
   // and commit_done coincide with the single APPLY cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= UPD_ST_IDLE;
         mode_q      <= UPD_ZERO;
         ratio_q     <= '0;
         ratio_cnt   <= '0;
         mask_event  <= 1'b0;
         commit_done <= 1'b0;
         commit_busy <= 1'b0;
      end else begin
         mask_event  <= 1'b0;
         commit_done <= 1'b0;
         case (state)
            UPD_ST_IDLE: begin
               // Events seen in the accepting cycle are deliberately not counted.
               if (commit_req) begin
                  state       <= UPD_ST_ARMED;
                  mode_q      <= upd_mode;
                  ratio_q     <= upd_ratio;
                  ratio_cnt   <= '0;
                  commit_busy <= 1'b1;
               end
            end
            UPD_ST_ARMED: begin
               if (apply_now) begin
                  state       <= UPD_ST_APPLY;
                  mask_event  <= 1'b1;
                  commit_done <= 1'b1;
               end else if (evt && (ratio_cnt < ratio_q)) begin
                  // Saturating count: it can never pass the latched ratio.
                  ratio_cnt <= ratio_cnt + 1'b1;
               end
            end
            UPD_ST_APPLY: begin
               state       <= UPD_ST_IDLE;
               commit_busy <= 1'b0;
            end
            default: begin
               state       <= UPD_ST_IDLE;
               commit_busy <= 1'b0;
            end
         endcase
      end
   end

   // A request while a commit is in flight is rejected and flagged one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) commit_err <= 1'b0;
      else       commit_err <= commit_req && (state != UPD_ST_IDLE);
   end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed bench for pwm_update_scheduler: a per-cycle vector table plus
// hand-written timelines for latency, immediate/err, carrier-off and reset.
module tb_pwm_update_scheduler;
   import PKG_pwm::*;

   logic         clk = 1'b0;
   logic         reset;
   _pwm_onoff    pwm_onoff;
   logic         cnt_zero, cnt_max;
   _pwm_upd_mode upd_mode;
   logic [7:0]   upd_ratio;
   logic         commit_req;
   logic         mask_event, commit_busy, commit_done, commit_err;

   int n_chk  = 0;
   int n_pass = 0;

   pwm_update_scheduler #(.RATIO_WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .pwm_onoff   (pwm_onoff),
      .cnt_zero    (cnt_zero),
      .cnt_max     (cnt_max),
      .upd_mode    (upd_mode),
      .upd_ratio   (upd_ratio),
      .commit_req  (commit_req),
      .mask_event  (mask_event),
      .commit_busy (commit_busy),
      .commit_done (commit_done),
      .commit_err  (commit_err)
   );

   always #5 clk = ~clk;

   // inputs for one cycle and outputs expected right after that cycle's edge
   typedef struct {
      logic       off;
      logic       z;
      logic       m;
      logic [1:0] mode;
      logic [7:0] ratio;
      logic       req;
      logic [3:0] exp;   // {mask_event, commit_busy, commit_done, commit_err}
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic off, input logic z, input logic m,
                               input logic [1:0] mode, input logic [7:0] ratio,
                               input logic req, input logic [3:0] exp);
      vec_t v;
      v.off = off; v.z = z; v.m = m; v.mode = mode;
      v.ratio = ratio; v.req = req; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      else
         n_pass++;
   endtask

   task automatic chk4(input string name, input logic [3:0] exp);
      chk({name, ".mask_event"},  mask_event,  exp[3]);
      chk({name, ".commit_busy"}, commit_busy, exp[2]);
      chk({name, ".commit_done"}, commit_done, exp[1]);
      chk({name, ".commit_err"},  commit_err,  exp[0]);
   endtask

   // Drive one cycle's inputs just after an edge, then sample 1 time unit after the next edge.
   task automatic step(input logic off, input logic z, input logic m,
                       input logic [1:0] mode, input logic [7:0] ratio,
                       input logic req);
      pwm_onoff  = off ? PWM_OFF : PWM_ON;
      cnt_zero   = z;
      cnt_max    = m;
      upd_mode   = _pwm_upd_mode'(mode);
      upd_ratio  = ratio;
      commit_req = req;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
   endtask

   initial begin
      // ---------------- reset state ----------------
      reset = 1'b1;
      pwm_onoff = PWM_ON; cnt_zero = 0; cnt_max = 0;
      upd_mode = UPD_ZERO; upd_ratio = 0; commit_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk4("reset", 4'b0000);
      reset = 1'b0;
      idle_cycles(1);
      chk4("post_reset", 4'b0000);

      // ---------------- vector table ----------------
      // ZERO, ratio 0: event with the accepted request is not counted
      tbl.push_back(mk(0,1,0, 2'd0, 8'd0, 1, 4'b0100));
      tbl.push_back(mk(0,0,0, 2'd0, 8'd0, 0, 4'b0100));
      tbl.push_back(mk(0,1,0, 2'd0, 8'd0, 0, 4'b1110));
      tbl.push_back(mk(0,0,0, 2'd0, 8'd0, 0, 4'b0000));
      // BOTH, ratio 2: max, zero+max together, zero -> apply after third
      tbl.push_back(mk(0,0,0, 2'd2, 8'd2, 1, 4'b0100));
      tbl.push_back(mk(0,0,1, 2'd2, 8'd2, 0, 4'b0100));
      tbl.push_back(mk(0,0,0, 2'd2, 8'd2, 0, 4'b0100));
      tbl.push_back(mk(0,1,1, 2'd2, 8'd2, 0, 4'b0100));
      tbl.push_back(mk(0,0,0, 2'd2, 8'd2, 0, 4'b0100));
      tbl.push_back(mk(0,1,0, 2'd2, 8'd2, 0, 4'b1110));
      tbl.push_back(mk(0,0,0, 2'd2, 8'd2, 0, 4'b0000));
      // ZERO, ratio 1; live ratio->5 and mode->IMMEDIATE while armed are ignored
      tbl.push_back(mk(0,0,0, 2'd0, 8'd1, 1, 4'b0100));
      tbl.push_back(mk(0,0,0, 2'd3, 8'd5, 0, 4'b0100));
      tbl.push_back(mk(0,0,1, 2'd3, 8'd5, 0, 4'b0100));
      tbl.push_back(mk(0,1,0, 2'd3, 8'd5, 0, 4'b0100));
      tbl.push_back(mk(0,1,0, 2'd3, 8'd5, 0, 4'b1110));
      // request during APPLY: rejected with err, not accepted afterwards
      tbl.push_back(mk(0,0,0, 2'd0, 8'd0, 1, 4'b0001));
      tbl.push_back(mk(0,0,0, 2'd0, 8'd0, 0, 4'b0000));
      // MAX, ratio 1: zero ignored; request in ARMED errs while apply proceeds
      tbl.push_back(mk(0,0,0, 2'd1, 8'd1, 1, 4'b0100));
      tbl.push_back(mk(0,1,0, 2'd1, 8'd1, 0, 4'b0100));
      tbl.push_back(mk(0,0,1, 2'd1, 8'd1, 0, 4'b0100));
      tbl.push_back(mk(0,0,1, 2'd0, 8'd0, 1, 4'b1111));
      tbl.push_back(mk(0,0,0, 2'd0, 8'd0, 0, 4'b0000));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].off, tbl[i].z, tbl[i].m, tbl[i].mode, tbl[i].ratio, tbl[i].req);
         chk4($sformatf("vec%0d", i), tbl[i].exp);
      end

      // ---------------- ZERO ratio 0: req at cycle 10, zero at 20 ----------------
      // outputs sampled after cycle c's edge belong to cycle c+1
      for (int c = 0; c < 25; c++) begin
         step(1'b0, (c == 20), 1'b0, 2'd0, 8'd0, (c == 10));
         chk($sformatf("lat_busy_c%0d", c + 1), commit_busy, (c + 1 >= 11) && (c + 1 <= 21));
         chk($sformatf("lat_mask_c%0d", c + 1), mask_event,  (c + 1 == 21));
         chk($sformatf("lat_done_c%0d", c + 1), commit_done, (c + 1 == 21));
      end

      // ---------------- IMMEDIATE: req at 5, second req at 6 ----------------
      for (int c = 0; c < 12; c++) begin
         step(1'b0, 1'b1, 1'b1, 2'd3, 8'd7, (c == 5) || (c == 6));
         chk($sformatf("imm_mask_c%0d", c + 1), mask_event,  (c + 1 == 7));
         chk($sformatf("imm_err_c%0d", c + 1),  commit_err,  (c + 1 == 7));
         chk($sformatf("imm_busy_c%0d", c + 1), commit_busy, (c + 1 == 6) || (c + 1 == 7));
      end

      // ---------------- MAX armed, carrier off at 30 with no events ----------------
      for (int c = 20; c < 36; c++) begin
         step((c >= 30), 1'b0, 1'b0, 2'd1, 8'd3, (c == 22));
         chk($sformatf("off_mask_c%0d", c + 1), mask_event,  (c + 1 == 31));
         chk($sformatf("off_busy_c%0d", c + 1), commit_busy, (c + 1 >= 23) && (c + 1 <= 31));
      end

      // ---------------- reset while ARMED, ratio 3, after 2 events ----------------
      step(1'b0, 1'b0, 1'b0, 2'd0, 8'd3, 1'b1);
      step(1'b0, 1'b1, 1'b0, 2'd0, 8'd3, 1'b0);
      step(1'b0, 1'b1, 1'b0, 2'd0, 8'd3, 1'b0);
      chk("rst_pre_busy", commit_busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk4("rst_async", 4'b0000);
      step(1'b0, 1'b1, 1'b0, 2'd0, 8'd3, 1'b1);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step(1'b0, 1'b1, 1'b0, 2'd0, 8'd3, 1'b0);
         chk4($sformatf("rst_after%0d", c), 4'b0000);
      end
      // fresh commit, ratio 1: applies on the second zero, not the first
      step(1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 1'b1);
      chk4("rst_new_arm", 4'b0100);
      step(1'b0, 1'b1, 1'b0, 2'd0, 8'd1, 1'b0);
      chk4("rst_new_ev1", 4'b0100);
      step(1'b0, 1'b1, 1'b0, 2'd0, 8'd1, 1'b0);
      chk4("rst_new_ev2", 4'b1110);
      step(1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 1'b0);
      chk4("rst_new_idle", 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
